// File: rtl/uart_word_tx_if.sv
// uart_word_tx_if: word write handshake between the response interpreter and the UART transmitter
interface uart_word_tx_if;
  logic        uart_write;
  logic [31:0] uart_write_data;
  logic        uart_response;
  logic        full;
  modport master (output uart_write, uart_write_data, input uart_response, full);
  modport slave (input uart_write, uart_write_data, output uart_response, full);
endinterface

// File: rtl/uart_word_tx.sv
// uart_word_tx: word FIFO feeding a UART serialiser, 4 bytes per word MSB byte first; UART_TX_PARITY_EN adds an even parity bit
module uart_word_tx #(
  parameter int CLOCK_FEQ  = 25000000,
  parameter int BIT_RATE   = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  uart_word_tx_if.slave  host,
  output logic           busy,
  output logic           tx
);
  localparam int CPB = CLOCK_FEQ / BIT_RATE;
  localparam int CW  = $clog2(CPB + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CPB_LAST = CW'(CPB - 1);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          push, pop, bit_end;
  state_t        state;
  logic [CW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [31:0]   sh;
  assign push      = host.uart_write && !host.full;
  assign pop       = (state == IDLE) && (count != '0);
  assign bit_end   = baud == CPB_LAST;
  assign busy      = (state != IDLE) || (count != '0);
  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
  // FIFO storage, written only on accepted pushes
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= host.uart_write_data;
  // FIFO pointers, occupancy and the registered full/response handshake
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      host.full          <= 1'b0;
      host.uart_response <= 1'b0;
    end else begin
      wr_ptr             <= wr_ptr + AW'(push);
      rd_ptr             <= rd_ptr + AW'(pop);
      count              <= count_nxt;
      host.full          <= count_nxt == (AW+1)'(FIFO_DEPTH);
      host.uart_response <= push;
    end
  // Serialiser: baud counter restarts on every state entry; tx is registered
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud     <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      sh       <= '0;
    end else begin
      baud <= (state == IDLE || bit_end) ? '0 : baud + 1'b1;
      case (state)
        IDLE: if (pop) begin
          state    <= START;
          tx       <= 1'b0;
          byte_cnt <= '0;
          sh       <= mem[rd_ptr];
        end
        START: if (bit_end) begin
          state   <= DATA;
          tx      <= sh[24];
          bit_cnt <= '0;
        end
        DATA: if (bit_end) begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state <= PARITY;
            tx    <= ^sh[31:24];
`else
            state <= STOP;
            tx    <= 1'b1;
`endif
          end else tx <= sh[{2'b11, bit_cnt} + 5'd1];
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (bit_end) begin
          state <= STOP;
          tx    <= 1'b1;
        end
`endif
        STOP: if (bit_end) begin
          state    <= (byte_cnt == 2'd3) ? IDLE : START;
          tx       <= byte_cnt == 2'd3;
          byte_cnt <= byte_cnt + 1'b1;
          sh       <= {sh[23:0], 8'h00};
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: directed and random checks of uart_word_tx against a line decoder and byte-queue model
module tb_uart_word_tx;
  localparam int CPB = 25;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  localparam int WORD = (NB + 1) * 4 * CPB;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy, tx;
  uart_word_tx_if bus ();
  uart_word_tx #(.CLOCK_FEQ(25000000), .BIT_RATE(1000000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .host(bus.slave), .busy(busy), .tx(tx));
  always #5 clk = ~clk;
  int checks = 0, failures = 0, cyc = 0, ph = 0, t1 = 0;
  logic [7:0] exp_q[$], rx_q[$];
  logic       par_q[$];
  logic [7:0] rx_b, bits;
  logic       rx_p, rx_on = 1'b0, low_seen;
  logic [31:0] w;
  logic [3:0]  pv;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic write_word(input logic [31:0] wd, input logic acc);
    bus.uart_write = 1'b1;
    bus.uart_write_data = wd;
    tick();
    bus.uart_write = 1'b0;
    chk("response", 64'(bus.uart_response), 64'(acc));
    if (acc) for (int i = 3; i >= 0; i--) exp_q.push_back(wd[8*i +: 8]);
  endtask
  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin
      tick();
      n++;
    end
    chk("idle_timeout", 64'(n < bound), 64'(1));
  endtask
  task automatic chk_line(input string tag);
    chk({tag, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      chk({tag, "_byte"}, 64'(rx_q[i]), 64'(exp_q[i]));
`ifdef UART_TX_PARITY_EN
      chk({tag, "_parity"}, 64'(par_q[i]), 64'(^exp_q[i]));
`endif
    end
    exp_q.delete();
    rx_q.delete();
    par_q.delete();
  endtask
  // line decoder: samples each bit at its middle, relative to the first low sample of the start bit
  always @(negedge clk) begin
    if (reset) rx_on = 1'b0;
    else if (!rx_on) begin
      if (tx === 1'b0) begin
        rx_on = 1'b1;
        ph = 0;
      end
    end else begin
      ph++;
      if (ph % CPB == CPB / 2) begin
        if (ph / CPB >= 1 && ph / CPB <= 8) rx_b[ph/CPB-1] = tx;
        else if (ph / CPB == NB) begin
          chk("stop_bit", 64'(tx), 64'(1));
          rx_q.push_back(rx_b);
          par_q.push_back(rx_p);
          rx_on = 1'b0;
        end else if (ph / CPB == 9) rx_p = tx;
      end
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    bus.uart_write = 1'b0;
    bus.uart_write_data = '0;
    #1 reset = 1'b1;
    #2;
    chk("rst_tx", 64'(tx), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_full", 64'(bus.full), 64'(0));
    chk("rst_resp", 64'(bus.uart_response), 64'(0));
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    write_word(32'hA5C30F01, 1'b1);
    chk("pre_pop_tx", 64'(tx), 64'(1));
    tick();
    t1 = cyc;
    chk("start_low", 64'(tx), 64'(0));
    repeat (24) tick();
    chk("start_end", 64'(tx), 64'(0));
    tick();
    for (int k = 0; k < 8; k++) begin
      repeat (12) tick();
      bits[k] = tx;
      repeat (13) tick();
    end
    chk("a5_bits", 64'(bits), 64'(8'b1010_0101));
    wait_idle(2 * WORD);
    chk("word_time", 64'(cyc - t1), 64'(WORD));
    chk_line("single");
    for (int i = 1; i <= 6; i++) begin
      write_word(32'(i), i <= 5);
      if (i == 4) chk("full_at4", 64'(bus.full), 64'(0));
      if (i >= 5) chk("full_at5", 64'(bus.full), 64'(1));
    end
    wait_idle(6 * WORD);
    chk_line("overflow");
    write_word(32'h1234_5678, 1'b1);
    write_word(32'h9ABC_DEF0, 1'b1);
    repeat (WORD - 1) tick();
    chk("gap_stop", 64'(tx), 64'(1));
    tick();
    chk("gap_idle", 64'(tx), 64'(1));
    tick();
    chk("gap_start", 64'(tx), 64'(0));
    wait_idle(2 * WORD);
    chk_line("spacing");
    for (int i = 0; i < 5; i++) write_word(32'h1000_0000 + 32'(i), 1'b1);
    repeat (WORD - 3) tick();
    chk("pp_full4", 64'(bus.full), 64'(1));
    write_word(32'hDEAD_BEEF, 1'b0);
    chk("pp_after_pop", 64'(bus.full), 64'(0));
    repeat (WORD) tick();
    write_word(32'hCAFE_0003, 1'b1);
    chk("pp_count3", 64'(bus.full), 64'(0));
    write_word(32'hCAFE_0004, 1'b1);
    chk("pp_refull", 64'(bus.full), 64'(1));
    wait_idle(8 * (WORD + 1));
    chk_line("pushpop");
    write_word(32'h5A00_FFFF, 1'b1);
    repeat (350) tick();
    chk("pre_reset_tx", 64'(tx), 64'(0));
    #1 reset = 1'b1;
    #1;
    chk("abort_tx", 64'(tx), 64'(1));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_full", 64'(bus.full), 64'(0));
    exp_q.delete();
    rx_q.delete();
    par_q.delete();
    tick();
    tick();
    reset = 1'b0;
    low_seen = 1'b0;
    repeat (300) begin
      tick();
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    chk("no_restart", 64'(low_seen), 64'(0));
    chk("no_bytes", 64'(rx_q.size()), 64'(0));
    for (int b = 0; b < 4; b++) begin
      int n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        write_word(w, 1'b1);
        if (i == 4) chk("rand_full", 64'(bus.full), 64'(1));
      end
      wait_idle(6 * (WORD + 1));
      chk_line("rand");
    end
`ifdef UART_TX_PARITY_EN
    write_word(32'h0103_0700, 1'b1);
    tick();
    t1 = cyc;
    wait_idle(2 * WORD);
    chk("par_word_time", 64'(cyc - t1), 64'(44 * CPB));
    chk("par_count", 64'(par_q.size()), 64'(4));
    if (par_q.size() == 4) begin
      pv = {par_q[0], par_q[1], par_q[2], par_q[3]};
      chk("par_bits", 64'(pv), 64'(4'b1010));
    end
    chk_line("parity");
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
